// File: rtl/ps2_kb_transmitter.sv
`timescale 1ns/1ps
// Device-side PS/2 transmitter: generates ps2clk, waits for an idle bus, shifts one
// scancode frame (start, D0..D7, odd parity, stop) and restarts on host inhibit.
module ps2_kb_transmitter #(
  parameter int HALF_PERIOD = 2000,
  parameter int IDLE_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        ps2clk_ext,
  inout  wire        ps2data_ext,
  input  logic [7:0] data,
  input  logic       dataload,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int PW = $clog2(HALF_PERIOD);
  localparam int IW = $clog2(IDLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BUS, S_BIT_HIGH, S_BIT_LOW} state_t;

  state_t          state, state_n;
  logic [1:0]      clk_sync, data_sync;
  logic            clk_s, data_s;
  logic [9:0]      shreg;
  logic [3:0]      bit_cnt;
  logic [PW-1:0]   phase_cnt;
  logic [IW-1:0]   idle_cnt;
  logic            idle_hit, inhibit, phase_end, last_bit, cur_bit;
  logic            clk_drv_low, data_drv_low;

  assign clk_s     = clk_sync[1];
  assign data_s    = data_sync[1];
  assign idle_hit  = clk_s && data_s && (idle_cnt == IW'(IDLE_CYCLES - 1));
  // Phases 0..2 still see our own released edge propagating through the synchronizer.
  assign inhibit   = (phase_cnt >= PW'(3)) && !clk_s;
  assign phase_end = (phase_cnt == PW'(HALF_PERIOD - 1));
  assign last_bit  = (bit_cnt == 4'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      clk_sync  <= '1;
      data_sync <= '1;
      shreg     <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      idle_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk_ext};
      data_sync <= {data_sync[0], ps2data_ext};
      state     <= state_n;
      done      <= 1'b0;
      aborted   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dataload) begin
            shreg    <= {1'b1, ~^data, data};
            busy     <= 1'b1;
            idle_cnt <= '0;
          end
        end
        S_WAIT_BUS: begin
          if (clk_s && data_s) begin
            if (idle_hit) begin
              idle_cnt  <= '0;
              bit_cnt   <= '0;
              phase_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        S_BIT_HIGH: begin
          if (inhibit) begin
            aborted  <= 1'b1;
            idle_cnt <= '0;
          end else if (phase_end) begin
            phase_cnt <= '0;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_BIT_LOW: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (last_bit) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (dataload) state_n = S_WAIT_BUS;
      S_WAIT_BUS: if (idle_hit) state_n = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (inhibit)        state_n = S_WAIT_BUS;
        else if (phase_end) state_n = S_BIT_LOW;
      end
      S_BIT_LOW:  if (phase_end) state_n = last_bit ? S_IDLE : S_BIT_HIGH;
      default:    state_n = S_IDLE;
    endcase
  end

  // Bit counter 0 is the start bit; counts 1..10 walk the shift register LSB first.
  always_comb begin
    cur_bit      = 1'b0;
    clk_drv_low  = 1'b0;
    data_drv_low = 1'b0;
    if (bit_cnt != 4'd0) cur_bit = shreg[bit_cnt - 4'd1];
    if (state == S_BIT_LOW) clk_drv_low = 1'b1;
    if ((state == S_BIT_HIGH) || (state == S_BIT_LOW)) data_drv_low = !cur_bit;
  end

  assign ps2clk_ext  = clk_drv_low  ? 1'b0 : 1'bz;
  assign ps2data_ext = data_drv_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_kb_transmitter.sv
`timescale 1ns/1ps
// Directed bench for ps2_kb_transmitter acting as a PS/2 host with pull-ups.
module tb_ps2_kb_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       dataload;
  logic       busy, done, aborted;
  logic       host_clk_low, host_data_low;
  wire        ps2clk, ps2data;

  pullup (ps2clk);
  pullup (ps2data);
  assign ps2clk  = host_clk_low  ? 1'b0 : 1'bz;
  assign ps2data = host_data_low ? 1'b0 : 1'bz;

  ps2_kb_transmitter #(.HALF_PERIOD(10), .IDLE_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .ps2clk_ext(ps2clk), .ps2data_ext(ps2data),
    .data(data), .dataload(dataload), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_bad = 0;
  int   n_abort = 0, n_both = 0;
  int   low_len = 0;
  logic prev_clk = 1'b1;
  logic bits_q[$];
  int   lens_q[$];

  // Host-side view: sample data on each ps2clk falling edge and time each low pulse.
  always @(negedge clk) begin
    if (prev_clk === 1'b1 && ps2clk === 1'b0) begin
      bits_q.push_back(ps2data);
      low_len = 1;
    end else if (ps2clk === 1'b0) begin
      low_len++;
    end else if (prev_clk === 1'b0 && ps2clk === 1'b1) begin
      lens_q.push_back(low_len);
    end
    prev_clk = ps2clk;
    if (aborted === 1'b1) n_abort++;
    if (done === 1'b1 && aborted === 1'b1) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is at a negedge; the following posedge accepts the load.
  task automatic load(input logic [7:0] b);
    data = b;
    dataload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dataload = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ps2data === 1'b0) break;
    end
    bits_q.delete();
    lens_q.delete();
  endtask

  task automatic wait_done(output int m);
    m = 0;
    while (m < 1000) begin
      @(posedge clk);
      @(negedge clk);
      m++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic par);
    logic [10:0] got;
    logic [10:0] exp;
    int bad_len;
    got = '0;
    for (int i = 0; i < bits_q.size() && i < 11; i++) got[i] = bits_q[i];
    exp = {1'b1, par, b, 1'b0};
    bad_len = 0;
    foreach (lens_q[i]) if (lens_q[i] != 10) bad_len++;
    chk({tag, "_bits"}, 32'(got), 32'(exp));
    chk({tag, "_nbits"}, bits_q.size(), 11);
    chk({tag, "_npulses"}, lens_q.size(), 11);
    chk({tag, "_pulse_len"}, bad_len, 0);
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] b, input logic par);
    int n, m;
    load(b);
    chk({tag, "_busy_set"}, busy, 1'b1);
    wait_start(n);
    chk({tag, "_start_lat"}, (n >= 20 && n <= 22), 1'b1);
    wait_done(m);
    chk({tag, "_done_at"}, m, 220);
    chk({tag, "_busy_clr"}, busy, 1'b0);
    @(negedge clk);
    check_frame(tag, b, par);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, ab0, drops;
    rst = 1'b1;
    data = '0;
    dataload = 1'b0;
    host_clk_low = 1'b0;
    host_data_low = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_lines", {ps2clk, ps2data}, 2'b11);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_and_check("f1c", 8'h1C, 1'b0);
    send_and_check("fff", 8'hFF, 1'b1);
    send_and_check("f00", 8'h00, 1'b1);
    send_and_check("f01", 8'h01, 1'b0);

    // Host inhibit during the high phase of D4 (bit counter 5).
    load(8'h1C);
    wait_start(n);
    repeat (104) @(negedge clk);
    ab0 = n_abort;
    drops = 0;
    host_clk_low = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b1) drops++;
    end
    chk("inh_abort_cnt", n_abort - ab0, 1);
    chk("inh_busy_held", drops, 0);
    chk("inh_data_rel", ps2data, 1'b1);
    host_clk_low = 1'b0;
    wait_start(n);
    chk("inh_restart_lat", (n >= 20 && n <= 24), 1'b1);
    wait_done(m);
    chk("inh_done_at", m, 220);
    @(negedge clk);
    check_frame("inh", 8'h1C, 1'b0);
    chk("inh_abort_total", n_abort - ab0, 1);

    // Host request-to-send holds data low: the block must stall.
    host_data_low = 1'b1;
    @(negedge clk);
    bits_q.delete();
    load(8'h00);
    repeat (100) @(negedge clk);
    chk("rts_no_clk", bits_q.size(), 0);
    chk("rts_busy", busy, 1'b1);
    host_data_low = 1'b0;
    wait_start(n);
    chk("rts_start_lat", (n >= 20 && n <= 24), 1'b1);
    wait_done(m);
    chk("rts_done_at", m, 220);
    @(negedge clk);
    check_frame("rts", 8'h00, 1'b1);

    // Load while busy is ignored; a load on the cycle after done is accepted.
    load(8'h1C);
    wait_start(n);
    repeat (50) @(negedge clk);
    load(8'h55);
    chk("bl_busy", busy, 1'b1);
    wait_done(m);
    chk("bl_done_seen", done, 1'b1);
    load(8'h55);
    check_frame("bl1c", 8'h1C, 1'b0);
    chk("bl_busy_reload", busy, 1'b1);
    wait_start(n);
    chk("bl55_start_lat", (n >= 20 && n <= 22), 1'b1);
    wait_done(m);
    chk("bl55_done_at", m, 220);
    @(negedge clk);
    check_frame("bl55", 8'h55, 1'b1);

    // Asynchronous reset while the block drives ps2clk low in bit 5.
    load(8'h1C);
    wait_start(n);
    repeat (115) @(negedge clk);
    chk("rstm_clk_low", ps2clk, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstm_lines", {ps2clk, ps2data}, 2'b11);
    chk("rstm_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    bits_q.delete();
    repeat (100) @(negedge clk);
    chk("rstm_quiet", bits_q.size(), 0);
    chk("rstm_busy_after", busy, 1'b0);

    chk("done_abort_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
